clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_pkg.sv | 40 ++++
 rtl/clk_div_chan.sv | 119 +++++++++++
 rtl/clk_div_prog.sv | 66 ++++++
 tb/tb_clk_div_prog.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Purpose  : Shared definitions for the programmable clock divider:
//             system clock frequency, divider mode encoding and a helper
//             that turns a target output frequency into a divisor value.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Frequency of the single system clock feeding every divider channel.
    localparam int unsigned CLK_FREQ = 50_000_000;

    // Output mode of a channel.
    //   MODE_TOGGLE : square wave, output inverts on every terminal count
    //   MODE_PULSE  : output is a one-cycle strobe on every terminal count
    typedef enum logic {
        MODE_TOGGLE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    // Divisor for a requested output frequency. In toggle mode the divisor
    // is a half-period, so the clock rate is split over two terminals. A
    // zero frequency returns 0, which the channel treats as divide-by-1.
    function automatic int unsigned div_from_freq(input int unsigned freq_hz,
                                                  input mode_e       mode);
        int unsigned result;
        result = 0;
        if (freq_hz != 0) begin
            if (mode == MODE_TOGGLE) begin
                result = CLK_FREQ / (2 * freq_hz);
            end else begin
                result = CLK_FREQ / freq_hz;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_chan
//  Purpose  : One programmable divider channel. Counts system clock cycles
//             up to an active divisor and produces a registered terminal
//             strobe (tick) and a divided output (toggle or pulse mode).
//             New divisor/mode values are staged in a pending register and
//             only promoted at a terminal count, so a running output never
//             sees a truncated or stretched period.
//  Ports    :
//    clk      in   system clock, rising edge
//    rst      in   synchronous active-high reset
//    en       in   run enable; low forces count/outputs to 0
//    wr_sel   in   write strobe already decoded for this channel
//    wr_div   in   new divisor (0 behaves as 1)
//    wr_mode  in   new mode (0 toggle, 1 pulse)
//    clk_div  out  divided output, registered
//    tick     out  one-cycle strobe following each terminal cycle
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_act_div;
    logic [CNT_W-1:0] r_pend_div;
    mode_e            r_act_mode;
    mode_e            r_pend_mode;
    logic             r_clk_div;
    logic             r_tick;

    logic [CNT_W-1:0] w_eff_div;
    logic             w_terminal;
    logic [CNT_W-1:0] w_next_div;
    mode_e            w_next_mode;

    always_comb begin
        w_eff_div   = (r_act_div == '0) ? c_one : r_act_div;
        // The count never exceeds the last value because the active divisor
        // only changes while the count is being reset to 0; using >= keeps
        // the channel self-recovering regardless.
        w_terminal  = (r_count >= (w_eff_div - c_one));
        // A write landing on the terminal cycle wins over the older pending
        // value, so the new divisor governs the very next period.
        w_next_div  = wr_sel ? wr_div : r_pend_div;
        w_next_mode = wr_sel ? mode_e'(wr_mode) : r_pend_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_act_div   <= c_default_div;
            r_pend_div  <= c_default_div;
            r_act_mode  <= MODE_TOGGLE;
            r_pend_mode <= MODE_TOGGLE;
            r_clk_div   <= 1'b0;
            r_tick      <= 1'b0;
        end else if (!en) begin
            // Idle channel: outputs parked low, configuration retained.
            // Writes take effect at once since no period is in progress.
            r_count   <= '0;
            r_clk_div <= 1'b0;
            r_tick    <= 1'b0;
            if (wr_sel) begin
                r_act_div   <= wr_div;
                r_pend_div  <= wr_div;
                r_act_mode  <= mode_e'(wr_mode);
                r_pend_mode <= mode_e'(wr_mode);
            end
        end else begin
            if (wr_sel) begin
                r_pend_div  <= wr_div;
                r_pend_mode <= mode_e'(wr_mode);
            end

            if (w_terminal) begin
                r_count    <= '0;
                r_tick     <= 1'b1;
                r_act_div  <= w_next_div;
                r_act_mode <= w_next_mode;
                if (w_next_mode != r_act_mode) begin
                    // Switching mode restarts the output from a known low.
                    r_clk_div <= 1'b0;
                end else if (w_next_mode == MODE_PULSE) begin
                    r_clk_div <= 1'b1;
                end else begin
                    r_clk_div <= ~r_clk_div;
                end
            end else begin
                r_count <= r_count + c_one;
                r_tick  <= 1'b0;
                if (r_act_mode == MODE_PULSE) begin
                    r_clk_div <= 1'b0;
                end
            end
        end
    end

    assign clk_div = r_clk_div;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Purpose  : Bank of NUM_CH independent programmable clock dividers sharing
//             one system clock and one divisor/mode write port.
//  Ports    :
//    clk      in   system clock, rising edge
//    rst      in   synchronous active-high reset
//    en       in   per-channel run enable               [NUM_CH]
//    wr_en    in   one-cycle divisor/mode write strobe
//    wr_ch    in   target channel of the write          [max(1,clog2(NUM_CH))]
//    wr_div   in   new divisor                          [CNT_W]
//    wr_mode  in   new mode (0 toggle, 1 pulse)
//    clk_div  out  per-channel divided output           [NUM_CH]
//    tick     out  per-channel terminal-count strobe    [NUM_CH]
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 32,
    parameter  int DEFAULT_DIV = 500_000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              wr_mode,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    // Writes addressed beyond the last channel are dropped here; this only
    // matters when NUM_CH is not a power of two.
    logic w_wr_valid;

    always_comb begin
        w_wr_valid = wr_en && (int'(wr_ch) < NUM_CH);
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        logic w_sel;

        assign w_sel = w_wr_valid && (wr_ch == CH_W'(gi));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en[gi]),
            .wr_sel  (w_sel),
            .wr_div  (wr_div),
            .wr_mode (wr_mode),
            .clk_div (clk_div[gi]),
            .tick    (tick[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Purpose  : Directed testbench for clk_div_prog. Main instance uses a short
//             default divisor (20) so reset-default behaviour is observable in
//             a few cycles; a second 3-channel instance exercises writes to a
//             channel index that does not exist.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    logic        clk;
    logic        rst;
    logic [3:0]  en;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [15:0] wr_div;
    logic        wr_mode;
    logic [3:0]  clk_div;
    logic [3:0]  tick;

    logic [2:0]  b_en;
    logic        b_wr_en;
    logic [1:0]  b_wr_ch;
    logic [7:0]  b_wr_div;
    logic        b_wr_mode;
    logic [2:0]  b_clk_div;
    logic [2:0]  b_tick;

    int vectors;
    int miscompares;
    int n;

    clk_div_prog #(
        .NUM_CH      (4),
        .CNT_W       (16),
        .DEFAULT_DIV (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .clk_div (clk_div),
        .tick    (tick)
    );

    clk_div_prog #(
        .NUM_CH      (3),
        .CNT_W       (8),
        .DEFAULT_DIV (2)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .en      (b_en),
        .wr_en   (b_wr_en),
        .wr_ch   (b_wr_ch),
        .wr_div  (b_wr_div),
        .wr_mode (b_wr_mode),
        .clk_div (b_clk_div),
        .tick    (b_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; return 1 time unit after the last edge.
    task automatic cyc(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Edges until tick[ch] is seen high (bounded; 200 means it never came).
    task automatic wait_tick(input int ch, output int cnt);
        cnt = 0;
        do begin
            cyc(1);
            cnt++;
        end while (!tick[ch] && cnt < 200);
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [15:0] d, input logic m);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = d;
        wr_mode = m;
        cyc(1);
        wr_en   = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
        b_en = '0; b_wr_en = 1'b0; b_wr_ch = '0; b_wr_div = '0; b_wr_mode = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("reset_clk_div", 32'(clk_div), 32'd0);
        chk("reset_tick",    32'(tick),    32'd0);

        // Defaults on channel 0: first tick 20 edges after enable, toggles.
        en = 4'b0001;
        wait_tick(0, n);
        chk("ch0_first_tick_latency", n, 20);
        chk("ch0_outputs_after_first", {24'd0, clk_div, tick}, {24'd0, 4'b0001, 4'b0001});
        wait_tick(0, n);
        chk("ch0_second_period", n, 20);
        chk("ch0_clk_div_low", 32'(clk_div), 32'd0);

        // Channel 1: divisor 3 written while idle, then enabled.
        do_write(2'd1, 16'd3, 1'b0);
        en = 4'b0011;
        wait_tick(1, n);
        chk("ch1_first_tick", n, 3);
        chk("ch1_clk_div_high", 32'(clk_div[1]), 32'd1);
        wait_tick(1, n);
        chk("ch1_period_a", n, 3);
        chk("ch1_clk_div_low", 32'(clk_div[1]), 32'd0);

        // Channel 2: div 10 running, write div 4 at count 5.
        do_write(2'd2, 16'd10, 1'b0);
        en = 4'b0111;
        wait_tick(2, n);
        chk("ch2_first_period", n, 10);
        cyc(5);
        do_write(2'd2, 16'd4, 1'b0);
        wait_tick(2, n);
        chk("ch2_period_during_write", n + 6, 10);
        wait_tick(2, n);
        chk("ch2_new_period", n, 4);

        // Write landing exactly on the terminal cycle governs the next period.
        cyc(3);
        do_write(2'd2, 16'd6, 1'b0);
        chk("ch2_terminal_write_tick", 32'(tick[2]), 32'd1);
        wait_tick(2, n);
        chk("ch2_period_after_term_write", n, 6);

        // Channel 3: div 0 in pulse mode behaves as div 1 -> held high.
        do_write(2'd3, 16'd0, 1'b1);
        en = 4'b1111;
        wait_tick(3, n);
        chk("ch3_div0_first_tick", n, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("ch3_div0_held", {30'd0, clk_div[3], tick[3]}, 32'd3);
        end
        en[3] = 1'b0;
        cyc(1);
        chk("ch3_disabled_outputs", {30'd0, clk_div[3], tick[3]}, 32'd0);
        do_write(2'd3, 16'd1, 1'b1);
        en[3] = 1'b1;
        wait_tick(3, n);
        chk("ch3_div1_first_tick", n, 1);
        cyc(1);
        chk("ch3_div1_held", {30'd0, clk_div[3], tick[3]}, 32'd3);

        // Channel 0: drop en mid-period with output high, reprogram, re-raise.
        for (int i = 0; i < 3; i++) begin
            wait_tick(0, n);
            if (clk_div[0]) break;
        end
        chk("ch0_high_before_drop", 32'(clk_div[0]), 32'd1);
        cyc(7);
        en[0] = 1'b0;
        cyc(1);
        chk("ch0_off_after_drop", {30'd0, clk_div[0], tick[0]}, 32'd0);
        do_write(2'd0, 16'd5, 1'b0);
        cyc(2);
        en[0] = 1'b1;
        wait_tick(0, n);
        chk("ch0_restart_latency", n, 5);
        chk("ch0_restart_clk_div", 32'(clk_div[0]), 32'd1);
        wait_tick(0, n);
        chk("ch0_restart_period", n, 5);

        // Channel 1: switch toggle -> pulse while running, output low at change.
        for (int i = 0; i < 3; i++) begin
            wait_tick(1, n);
            if (!clk_div[1]) break;
        end
        do_write(2'd1, 16'd3, 1'b1);
        wait_tick(1, n);
        chk("ch1_mode_change_period", n, 2);
        chk("ch1_mode_change_clear", 32'(clk_div[1]), 32'd0);
        wait_tick(1, n);
        chk("ch1_pulse_period", n, 3);
        chk("ch1_pulse_high", 32'(clk_div[1]), 32'd1);
        cyc(1);
        chk("ch1_pulse_low", 32'(clk_div[1]), 32'd0);

        // Simultaneous terminals on channels 0 and 1.
        en = 4'b0000;
        cyc(1);
        chk("all_disabled", {24'd0, clk_div, tick}, 32'd0);
        do_write(2'd0, 16'd4, 1'b0);
        do_write(2'd1, 16'd4, 1'b0);
        en = 4'b0011;
        wait_tick(0, n);
        chk("simul_latency", n, 4);
        chk("simul_tick", 32'(tick), 32'd3);

        // Reset mid-period together with a write: write dropped, defaults back.
        cyc(2);
        rst = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd2; wr_mode = 1'b1;
        cyc(1);
        chk("reset_midperiod_outputs", {24'd0, clk_div, tick}, 32'd0);
        rst = 1'b0;
        wr_en = 1'b0;
        en = 4'b0001;
        wait_tick(0, n);
        chk("post_reset_default_div", n, 20);
        chk("post_reset_toggle", 32'(clk_div), 32'd1);

        // Out-of-range channel write on the 3-channel instance is ignored.
        b_wr_en = 1'b1; b_wr_ch = 2'd3; b_wr_div = 8'd5; b_wr_mode = 1'b1;
        cyc(1);
        b_wr_en = 1'b0;
        b_en = 3'b111;
        cyc(2);
        chk("oor_tick", 32'(b_tick), 32'd7);
        chk("oor_clk_div", 32'(b_clk_div), 32'd7);
        cyc(1);
        chk("oor_tick_low", 32'(b_tick), 32'd0);
        chk("oor_clk_div_held", 32'(b_clk_div), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
